// File: rtl/pipe_mdu_ctrl.sv
// pipe_mdu_ctrl: hazard/sequencing controller beside the decode stage.
// Launches the multi-cycle MDU, times its HI/LO write, and produces the
// PC/IF-ID stall plus the ID/EX bubble for MDU-busy and load-use hazards.
module pipe_mdu_ctrl #(
  parameter int MUL_CYCLES = 5,   // mdu_go -> hilo_we for mult/multu
  parameter int DIV_CYCLES = 32,  // mdu_go -> hilo_we for div/divu
  parameter int CNT_W      = 5    // holds max(MUL_CYCLES, DIV_CYCLES) - 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       emd_start,
  input  logic [1:0] emd_op,
  input  logic       dmfhilo,
  input  logic       dmd,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic [4:0] drs,
  input  logic [4:0] drt,
  input  logic       drsrd,
  input  logic       drtrd,
  output logic       wpcir,
  output logic       dbubble,
  output logic       mdu_go,
  output logic [1:0] mdu_op,
  output logic       hilo_we,
  output logic       mdu_busy,
  output logic       md_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter preload: BUSY lasts (N-1) cycles, DONE is cycle N after mdu_go.
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mdu_op_q, mdu_op_d;
  logic             md_err_q, md_err_d;

  logic accept;
  logic stall_md;
  logic stall_lu;
  logic rs_hit;
  logic rt_hit;

  // New op accepted only when the unit is free or finishing this cycle.
  assign accept = emd_start & ((state_q == S_IDLE) | (state_q == S_DONE));

  // Next-state, counter, latched op and sticky protocol-error flag.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mdu_op_d = mdu_op_q;
    md_err_d = md_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_BUSY;
          mdu_op_d = emd_op;
          count_d  = emd_op[1] ? DIV_LD : MUL_LD;
        end
      end
      S_BUSY: begin
        // A start while busy is ignored; the running op keeps its timing.
        if (emd_start) md_err_d = 1'b1;
        if (count_q == '0) state_d = S_DONE;
        else               count_d = count_q - CNT_W'(1);
      end
      S_DONE: begin
        // Back-to-back: old result written while the new op launches.
        if (accept) begin
          state_d  = S_BUSY;
          mdu_op_d = emd_op;
          count_d  = emd_op[1] ? DIV_LD : MUL_LD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; clr overrides every other event.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mdu_op_q <= 2'b00;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mdu_op_q <= mdu_op_d;
      md_err_q <= md_err_d;
    end
  end

  // MDU-side outputs: go is combinational so operands are sampled in E now.
  assign mdu_go   = accept;
  assign mdu_op   = mdu_op_q;
  assign hilo_we  = (state_q == S_DONE);
  assign mdu_busy = (state_q == S_BUSY) | (state_q == S_DONE);
  assign md_err   = md_err_q;

  // DONE does not stall: HI/LO lands before a D-stage reader reaches E.
  assign stall_md = (dmfhilo | dmd) & ((state_q == S_BUSY) | emd_start);

  // Load-use: E-stage load targets a register D reads; r0 never hazards.
  assign rs_hit   = drsrd & (ern == drs);
  assign rt_hit   = drtrd & (ern == drt);
  assign stall_lu = ewreg & em2reg & (ern != 5'd0) & (rs_hit | rt_hit);

  assign wpcir   = ~(stall_md | stall_lu);
  assign dbubble = ~wpcir;

endmodule
